// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a prefetch queue.
// Issues sequential word fetches to a 1-cycle-latency instruction memory,
// buffers up to DEPTH {pc, inst} pairs and hands them to decode through a
// show-ahead valid/ready head. Branch and exception redirects flush the
// queue and drop the response of the fetch that is in flight.
//
// Handshake: the head entry transfers on a rising edge where inst_valid and
// inst_ready are both high; inst_valid never depends on inst_ready, and the
// head (inst_out/pc_out) stays stable while inst_valid is high and
// inst_ready is low. In a redirect cycle inst_ready is ignored.
module if_prefetch #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  EXC_VECTOR = 32'h8000_0180
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         br,
    input  logic [ADDR_W-1:0]            br_target,
    input  logic                         except,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    output logic                         inst_valid,
    output logic [DATA_W-1:0]            inst_out,
    output logic [ADDR_W-1:0]            pc_out,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fpc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [CW:0]       slots_used;
    logic              push;
    logic              pop;

    // Redirect decode, slot reservation and handshake qualifiers.
    always_comb begin
        redirect   = except | br;
        target     = except ? EXC_VECTOR : {br_target[ADDR_W-1:2], 2'b00};
        // Entries held plus the one response still on its way: reserving the
        // slot at request time means a push never finds the queue full.
        slots_used = {1'b0, count_q} + {{CW{1'b0}}, inflight};
        imem_req   = rst_n & ~redirect & (slots_used < (CW+1)'(DEPTH));
        // A response that lands in a redirect cycle belongs to the old path.
        push       = inflight & ~redirect;
        pop        = inst_valid & inst_ready & ~redirect;
    end

    assign imem_addr  = fpc;
    assign inst_valid = (count_q != '0);
    assign count      = count_q;
    assign inst_out   = inst_mem[rd_ptr];
    assign pc_out     = pc_mem[rd_ptr];

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fpc;
            end
            if (redirect) begin
                fpc <= target;
            end else if (imem_req) begin
                fpc <= fpc + ADDR_W'(4);
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; cleared on reset so the head never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: table-driven stall sequence, hand-written redirect,
// wrap and reset sequences, then randomized traffic against a queue model.
module tb_if_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] EXC   = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_target = '0;
    logic        except = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready = 1'b0;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch pc, pcs of requests awaiting data, queued pcs.
    logic [31:0] m_fpc;
    logic [31:0] m_pend[$];
    logic [31:0] m_q[$];

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        int          exp_count;
    } vec_t;

    vec_t tbl[12];

    if_prefetch #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000), .EXC_VECTOR(EXC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .br(br), .br_target(br_target),
        .except(except), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_out(inst_out),
        .pc_out(pc_out), .inst_ready(inst_ready), .count(count)
    );

    // Clock.
    always #5 clk = ~clk;

    // Instruction memory: 1-cycle latency, garbage when nothing was asked.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
        else          imem_rdata <= $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = 32'h0;
        m_pend.delete();
        m_q.delete();
    endtask

    function automatic logic model_req();
        return !(br | except) && (m_q.size() + m_pend.size() < DEPTH);
    endfunction

    // Drive inputs just after the falling edge and let outputs settle.
    task automatic drive(input logic b, input logic [31:0] bt, input logic e, input logic r);
        br = b; br_target = bt; except = e; inst_ready = r;
        #1;
    endtask

    task automatic check_model();
        logic req;
        req = model_req();
        chk("imem_req", {31'b0, imem_req}, {31'b0, req});
        if (req) chk("imem_addr", imem_addr, m_fpc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() != 0});
        chk("count", {29'b0, count}, 32'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("pc_out", pc_out, m_q[0]);
            chk("inst_out", inst_out, m_q[0] ^ KEY);
        end
    endtask

    // Apply the spec rules for one clock edge, then move to the next falling edge.
    task automatic advance();
        logic req;
        req = model_req();
        if (br | except) begin
            m_q.delete();
            m_pend.delete();
            m_fpc = except ? EXC : {br_target[31:2], 2'b00};
        end else begin
            if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
            if (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
            if (req) begin
                m_pend.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic b, input logic [31:0] bt, input logic e, input logic r);
        drive(b, bt, e, r);
        check_model();
        advance();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req},   32'h0);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_inst"},  inst_out,            32'h0);
        chk({tag, "_pc"},    pc_out,              32'h0);
        chk({tag, "_count"}, {29'b0, count},      32'h0);
    endtask

    // Reset held across two edges, released on a falling edge (cycle C0 follows).
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        br = 1'b0; except = 1'b0; inst_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // C0..C11 from reset with decode stalled until C7.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 0};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 0};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 2};
        tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 3};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3};
        tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 2};
        tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 2};
        tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 2};

        #2;
        @(negedge clk);
        do_reset("rst0");
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0, 1'b0, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_count", i), {29'b0, count}, 32'(tbl[i].exp_count));
            check_model();
            advance();
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Streaming from reset: one PC per cycle starting at C2.
        do_reset("rst1");
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            if (i >= 2) chk("stream_pc", pc_out, 32'((i - 2) * 4));
            check_model();
            advance();
        end

        // Branch with two entries queued.
        do_reset("rst2");
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0103, 1'b0, 1'b1);
        chk("br_t_count", {29'b0, count}, 32'd2);
        chk("br_t_req", {31'b0, imem_req}, 32'h0);
        check_model(); advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("br_t1_valid", {31'b0, inst_valid}, 32'h0);
        chk("br_t1_addr", imem_addr, 32'h0000_0100);
        check_model(); advance();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("br_t3_pc", pc_out, 32'h0000_0100);
        check_model(); advance();

        // Exception and branch together: exception vector wins.
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        check_model(); advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("exc_addr", imem_addr, EXC);
        check_model(); advance();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Back-to-back redirects: the later target wins.
        step(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0800, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rr_addr", imem_addr, 32'h0000_0800);
        check_model(); advance();

        // Address wrap.
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        check_model(); advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        check_model(); advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        check_model(); advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_pc1", pc_out, 32'h0000_0000);
        check_model(); advance();

        // Reset mid-operation with entries queued and a fetch in flight.
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        do_reset("rst3");
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            if (i == 0) chk("restart_addr", imem_addr, 32'h0);
            if (i == 2) chk("restart_pc", pc_out, 32'h0);
            check_model(); advance();
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        b, e, r;
            logic [31:0] bt;
            r  = ($urandom_range(0, 9) < 7);
            b  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 49) == 0);
            bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : $urandom();
            step(b, bt, e, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
